// File: rtl/case_8_sdiv_16s_7s_11_seq_1_if.sv
// Handshake and data bundle for the sequential signed divider.
// The master drives requests; the slave (divider core) returns results.
interface case_8_sdiv_16s_7s_11_seq_1_if #(
    parameter int W = 16,
    parameter int D = 7,
    parameter int Q = 11
);
    logic         ce;
    logic         start;
    logic [W-1:0] din0;
    logic [D-1:0] din1;
    logic         busy;
    logic         done;
    logic [Q-1:0] quot;
    logic [D-1:0] remd;
    logic         dbz;

    modport master (
        output ce, start, din0, din1,
        input  busy, done, quot, remd, dbz
    );

    modport slave (
        input  ce, start, din0, din1,
        output busy, done, quot, remd, dbz
    );
endinterface

// File: rtl/case_8_sdiv_16s_7s_11_seq_1.sv
// Radix-2 restoring signed divider: 16s / 7s -> 11s quotient, 7s remainder.
// One quotient bit per enabled cycle; signs are fixed up in a final cycle.
module case_8_sdiv_16s_7s_11_seq_1 #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 11,
    parameter int NUM_STAGE  = 18
) (
    input  logic ap_clk,
    input  logic ap_rst,
    case_8_sdiv_16s_7s_11_seq_1_if.slave bus
);

    localparam int W  = din0_WIDTH;
    localparam int D  = din1_WIDTH;
    localparam int Q  = dout_WIDTH;
    localparam int RW = D + 1;
    localparam int CW = $clog2(W);

    // ID and NUM_STAGE are informational; this block keeps them referenced.
    if (ID < 0 || NUM_STAGE != W + 2) begin : g_param_info
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  dvd_q,   dvd_d;
    logic [D-1:0]  dsr_q,   dsr_d;
    logic [RW-1:0] rem_q,   rem_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          sgn0_q,  sgn0_d;
    logic          sgn1_q,  sgn1_d;
    logic [D-1:0]  dlo_q,   dlo_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          dbz_q,   dbz_d;
    logic [Q-1:0]  quot_q,  quot_d;
    logic [D-1:0]  remd_q,  remd_d;

    logic [RW:0]   trial;
    logic          ge;

    always_comb begin
        trial = {rem_q, dvd_q[W-1]};
        ge    = (trial >= {2'b00, dsr_q});
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn0_d  = sgn0_q;
        sgn1_d  = sgn1_q;
        dlo_d   = dlo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        remd_d  = remd_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sgn0_d  = bus.din0[W-1];
                    sgn1_d  = bus.din1[D-1];
                    dbz_d   = (bus.din1 == '0);
                    dvd_d   = bus.din0[W-1] ? -bus.din0 : bus.din0;
                    dsr_d   = bus.din1[D-1] ? -bus.din1 : bus.din1;
                    dlo_d   = bus.din0[D-1:0];
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // The dividend register shifts out its MSB and fills with quotient bits.
                rem_d = RW'(ge ? trial - {2'b00, dsr_q} : trial);
                dvd_d = {dvd_q[W-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    quot_d = '1;
                    remd_d = dlo_q;
                end else begin
                    quot_d = Q'((sgn0_q ^ sgn1_q) ? -dvd_q : dvd_q);
                    remd_d = D'(sgn0_q ? -rem_q : rem_q);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn0_q  <= 1'b0;
            sgn1_q  <= 1'b0;
            dlo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else if (bus.ce) begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn0_q  <= sgn0_d;
            sgn1_q  <= sgn1_d;
            dlo_q   <= dlo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.remd = remd_q;
    assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_case_8_sdiv_16s_7s_11_seq_1.sv
// Directed bench for the sequential signed divider; cycle 1 is the first
// cycle after the edge that accepts start.
module tb_case_8_sdiv_16s_7s_11_seq_1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    case_8_sdiv_16s_7s_11_seq_1_if #(.W(16), .D(7), .Q(11)) bus_if ();

    case_8_sdiv_16s_7s_11_seq_1 #(
        .ID(1), .din0_WIDTH(16), .din1_WIDTH(7), .dout_WIDTH(11), .NUM_STAGE(18)
    ) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [6:0] b);
        bus_if.din0  = a;
        bus_if.din1  = b;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
    endtask

    // Advance until done rises (bounded); returns the cycle number it was seen in.
    task automatic wait_done(input int c0, output int cyc, output int bcnt);
        cyc  = c0;
        bcnt = 0;
        while (!bus_if.done && cyc < 60) begin
            if (bus_if.busy) bcnt++;
            step();
            cyc++;
        end
    endtask

    logic [15:0] va [7];
    logic [6:0]  vb [7];
    logic [10:0] vq [7];
    logic [6:0]  vr [7];
    logic        vz [7];

    initial begin
        int cyc, bcnt, nd;

        va[0] = 16'hFC18; vb[0] = 7'h07; vq[0] = 11'h772; vr[0] = 7'h7A; vz[0] = 1'b0;
        va[1] = 16'd1000; vb[1] = 7'h79; vq[1] = 11'h772; vr[1] = 7'h06; vz[1] = 1'b0;
        va[2] = 16'hFC18; vb[2] = 7'h79; vq[2] = 11'h08E; vr[2] = 7'h7A; vz[2] = 1'b0;
        va[3] = 16'd123;  vb[3] = 7'h00; vq[3] = 11'h7FF; vr[3] = 7'h7B; vz[3] = 1'b1;
        va[4] = 16'h8000; vb[4] = 7'h7F; vq[4] = 11'h000; vr[4] = 7'h00; vz[4] = 1'b0;
        va[5] = 16'h7FFF; vb[5] = 7'h40; vq[5] = 11'h601; vr[5] = 7'h3F; vz[5] = 1'b0;
        va[6] = 16'hFFC0; vb[6] = 7'h40; vq[6] = 11'h001; vr[6] = 7'h00; vz[6] = 1'b0;

        // Reset overrides ce=0
        rst          = 1'b1;
        bus_if.ce    = 1'b0;
        bus_if.start = 1'b0;
        bus_if.din0  = '0;
        bus_if.din1  = '0;
        step();
        step();
        check("rst_busy", {31'b0, bus_if.busy}, 32'd0);
        check("rst_done", {31'b0, bus_if.done}, 32'd0);
        check("rst_quot", {21'b0, bus_if.quot}, 32'd0);
        check("rst_remd", {25'b0, bus_if.remd}, 32'd0);
        check("rst_dbz",  {31'b0, bus_if.dbz},  32'd0);
        rst       = 1'b0;
        bus_if.ce = 1'b1;
        step();

        // Basic 1000/7
        issue(16'd1000, 7'd7);
        wait_done(1, cyc, bcnt);
        check("basic_lat",  cyc, 32'd18);
        check("basic_busy", bcnt, 32'd17);
        check("basic_quot", {21'b0, bus_if.quot}, 32'h08E);
        check("basic_remd", {25'b0, bus_if.remd}, 32'h06);
        check("basic_dbz",  {31'b0, bus_if.dbz},  32'd0);
        check("basic_nbusy", {31'b0, bus_if.busy}, 32'd0);
        step();
        check("done_pulse", {31'b0, bus_if.done}, 32'd0);
        check("hold_quot",  {21'b0, bus_if.quot}, 32'h08E);

        // Sign, divide-by-zero and extreme vectors
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i]);
            wait_done(1, cyc, bcnt);
            check($sformatf("v%0d_lat", i),  cyc, 32'd18);
            check($sformatf("v%0d_quot", i), {21'b0, bus_if.quot}, {21'b0, vq[i]});
            check($sformatf("v%0d_remd", i), {25'b0, bus_if.remd}, {25'b0, vr[i]});
            check($sformatf("v%0d_dbz", i),  {31'b0, bus_if.dbz},  {31'b0, vz[i]});
            step();
        end

        // Start while busy is ignored
        issue(16'd1000, 7'd7);
        step(); step(); step();
        bus_if.din0  = 16'd5;
        bus_if.din1  = 7'd1;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        wait_done(5, cyc, bcnt);
        check("ign_lat",  cyc, 32'd18);
        check("ign_quot", {21'b0, bus_if.quot}, 32'h08E);
        check("ign_remd", {25'b0, bus_if.remd}, 32'h06);
        step();

        // ce low for 5 cycles mid-DIV, then freeze of the done pulse
        issue(16'd1000, 7'd7);
        step(); step(); step(); step();
        bus_if.ce = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("ce_busy_hold", {31'b0, bus_if.busy}, 32'd1);
        bus_if.ce = 1'b1;
        wait_done(10, cyc, bcnt);
        check("ce_lat",  cyc, 32'd23);
        check("ce_quot", {21'b0, bus_if.quot}, 32'h08E);
        bus_if.ce = 1'b0;
        step(); step();
        check("ce_done_hold", {31'b0, bus_if.done}, 32'd1);
        bus_if.ce = 1'b1;
        step();
        check("ce_done_clr", {31'b0, bus_if.done}, 32'd0);

        // Back-to-back: start accepted in the done cycle
        issue(16'd1000, 7'd7);
        wait_done(1, cyc, bcnt);
        check("b2b_lat0", cyc, 32'd18);
        issue(16'hFC18, 7'h79);
        wait_done(1, cyc, bcnt);
        check("b2b_lat1", cyc, 32'd18);
        check("b2b_quot", {21'b0, bus_if.quot}, 32'h08E);
        check("b2b_remd", {25'b0, bus_if.remd}, 32'h7A);
        step();

        // Reset mid-operation
        issue(16'd500, 7'd3);
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_busy", {31'b0, bus_if.busy}, 32'd0);
        check("mrst_done", {31'b0, bus_if.done}, 32'd0);
        check("mrst_quot", {21'b0, bus_if.quot}, 32'd0);
        check("mrst_remd", {25'b0, bus_if.remd}, 32'd0);
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.done) nd++;
            step();
        end
        check("mrst_nodone", nd, 32'd0);
        issue(16'd500, 7'd3);
        wait_done(1, cyc, bcnt);
        check("fresh_lat",  cyc, 32'd18);
        check("fresh_quot", {21'b0, bus_if.quot}, 32'd166);
        check("fresh_remd", {25'b0, bus_if.remd}, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/case_8_sdiv_16s_7s_11_seq_1.md
Name: case_8_sdiv_16s_7s_11_seq_1

Overview:
- Multi-cycle signed integer divider; the inverse of the 11s x 7s -> 16 signed multiply operator.
- Takes a 16-bit signed dividend and a 7-bit signed divisor. Returns an 11-bit signed quotient and a 7-bit signed remainder.
- Radix-2 restoring, one quotient bit per cycle, start/done handshake, clock-enable controlled.
- Instantiated by the HLS datapath wherever a scheduled sdiv/srem op needs a sequential core.

Parameters:
- ID, 1, instance identifier; no functional effect.
- din0_WIDTH, 16, dividend width (W).
- din1_WIDTH, 7, divisor and remainder width (D).
- dout_WIDTH, 11, quotient width (Q); quotient is truncated to its low Q bits.
- NUM_STAGE, 18, documented latency = din0_WIDTH+2; informational only.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- ce  in  1  clock enable; when low, all state, counters and outputs hold.
- start  in  1  request; sampled only in IDLE with ce=1.
- din0  in  W  signed dividend; captured on the accepted start.
- din1  in  D  signed divisor; captured on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; quot/remd/dbz are valid in the same cycle.
- quot  out  Q  signed quotient, registered.
- remd  out  D  signed remainder, registered.
- dbz  out  1  divide-by-zero flag for the last result.

Behaviour:
- Reset (ap_rst=1 at an edge, overrides ce): state=IDLE, busy=0, done=0, quot=0, remd=0, dbz=0, internal registers cleared.
- States: IDLE -> DIV -> FIX -> IDLE.
- IDLE, on start=1 and ce=1:
  - capture sign(din0), sign(din1), dbz=(din1==0);
  - load |din0| as W-bit unsigned (|-32768|=32768) into the shift register and |din1| as D-bit unsigned;
  - partial remainder = 0 (D+1 bits), counter = 0; go to DIV.
- DIV, W iterations:
  - shift the remainder left, bringing in the dividend MSB;
  - trial-subtract |divisor|; if non-negative keep the difference and shift in quotient bit 1, else restore and shift in 0;
  - counter increments; after the iteration with counter==W-1, go to FIX.
- FIX, one cycle:
  - quotient negated if sign(din0)^sign(din1);
  - remainder negated if sign(din0) (truncating division: remainder takes the dividend's sign);
  - register quot = low Q bits of the signed quotient and remd = low D bits of the signed remainder;
  - done=1 for one cycle; go to IDLE.
- Divide by zero: quot = all ones, remd = din0[D-1:0], dbz=1; timing unchanged (still W+2 cycles).
- Overflow or out-of-range quotient (e.g. -32768 / -1): result silently truncated to Q bits, no flag.
- Latency: start accepted at edge N -> done high during cycle N+W+2 (18 for defaults), counted in ce=1 cycles.
- Throughput: next start is accepted in the cycle done is high (state is IDLE); back-to-back spacing is W+2.
- start while busy: ignored, with no effect on the operation in progress.
- ce=0 during any state: everything frozen, including a done pulse (done stays high until the next ce=1 edge clears it).
- Outputs hold their last result between done pulses; busy=0 in IDLE.
- Reset mid-operation: aborts immediately with no done pulse; outputs return to 0.

Test Plan:
- Basic: din0=1000, din1=7, start 1 cycle, ce=1 -> busy for 17 cycles, done at cycle 18, quot=142 (11'h08E), remd=6 (7'h06), dbz=0.
- Signs:
  - -1000/7 -> quot=11'h772 (-142), remd=7'h7A (-6);
  - 1000/-7 -> quot=11'h772, remd=7'h06;
  - -1000/-7 -> quot=11'h08E, remd=7'h7A.
- Divide by zero: din0=123, din1=0 -> done at cycle 18, dbz=1, quot=11'h7FF, remd=7'h7B.
- Extremes:
  - -32768/-1 -> quot=11'h000, remd=0;
  - 32767/-64 -> quot=11'h601 (-511), remd=7'h3F (63);
  - -64/-64 -> quot=1, remd=0.
- Handshake and ce: during op A (1000/7), assert start with 5/1 at cycle 4 -> ignored, A's result unchanged. Drop ce for 5 cycles mid-DIV -> done at cycle 23. Issue a start in the done cycle -> accepted, next done 18 cycles later.
- Reset mid-op: start 500/3, pulse ap_rst at cycle 8 -> busy=0, no done, quot=remd=0. A fresh 500/3 then gives quot=166, remd=2 after 18 cycles.
